// File: rtl/field_mux_pipe_if.sv
// field_mux_pipe_if -- handshake bundle between a producer, field_mux_pipe and
// a consumer.
//
// Upstream side (producer -> mux):
//   i_data  [NCH*W]  packed fields, field k = i_data[k*W +: W]
//   i_sel   [SEL_W]  field index used for a select-mode beat
//   i_mode           0 = select one field, 1 = scan all fields
//   i_valid          upstream beat valid
//   o_ready          mux can take an upstream beat (registered)
// Downstream side (mux -> consumer):
//   o_data  [W]      selected field
//   o_sel   [SEL_W]  index of the field on o_data
//   o_last           final beat of a transfer
//   o_valid          downstream beat valid
//   i_ready          consumer accepts the beat
//
// Modports: slave = the mux itself, master = the environment around it.
interface field_mux_pipe_if #(
  parameter int W     = 3,
  parameter int SEL_W = 2
);
  localparam int NCH = 2 ** SEL_W;

  logic [NCH*W-1:0] i_data;
  logic [SEL_W-1:0] i_sel;
  logic             i_mode;
  logic             i_valid;
  logic             o_ready;
  logic [W-1:0]     o_data;
  logic [SEL_W-1:0] o_sel;
  logic             o_last;
  logic             o_valid;
  logic             i_ready;

  modport slave (
    input  i_data, i_sel, i_mode, i_valid, i_ready,
    output o_ready, o_data, o_sel, o_last, o_valid
  );

  modport master (
    output i_data, i_sel, i_mode, i_valid, i_ready,
    input  o_ready, o_data, o_sel, o_last, o_valid
  );
endinterface

// File: rtl/field_mux_pipe.sv
// field_mux_pipe -- picks one W-bit field out of a packed word and streams it
// through a 2-entry skid buffer (main register + skid register).
//
// Ports:
//   i_clk    single clock, rising edge
//   i_rst_n  asynchronous, active-low reset
//   bus      field_mux_pipe_if.slave (see the interface file for signals)
//
// Select mode: an accepted beat pushes field i_sel with o_last = 1, visible
// on the output one cycle after acceptance.
//
// Optional feature, macro FIELD_MUX_SCAN_EN: when defined, an accepted beat
// with i_mode = 1 snapshots i_data and streams all NCH fields in index order
// (o_last on the final one) through a two-state FSM. When undefined, i_mode
// is ignored and every accepted beat is a select-mode beat.
module field_mux_pipe #(
  parameter int W     = 3,
  parameter int SEL_W = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  field_mux_pipe_if.slave bus
);
  localparam int NCH = 2 ** SEL_W;

  typedef struct packed {
    logic [W-1:0]     data;
    logic [SEL_W-1:0] sel;
    logic             last;
  } beat_t;

  // Unpack the live input word into an indexable array of fields.
  logic [W-1:0] in_field [NCH];
  for (genvar gi = 0; gi < NCH; gi++) begin : g_in_field
    assign in_field[gi] = bus.i_data[gi*W +: W];
  end

  logic  accept;
  logic  pop;
  logic  push;
  beat_t push_beat;
  logic  idle_d;

  logic  m_valid_q, m_valid_d;
  logic  s_valid_q, s_valid_d;
  beat_t m_beat_q, m_beat_d;
  beat_t s_beat_q, s_beat_d;
  logic  ready_q, ready_d;

  assign accept = bus.i_valid & ready_q;
  assign pop    = m_valid_q & bus.i_ready;

`ifdef FIELD_MUX_SCAN_EN
  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [NCH*W-1:0] snap_q, snap_d;
  logic [SEL_W-1:0] idx_q, idx_d;

  logic [W-1:0] snap_field [NCH];
  for (genvar gi = 0; gi < NCH; gi++) begin : g_snap_field
    assign snap_field[gi] = snap_q[gi*W +: W];
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic. The scan-entry accept itself pushes nothing; the
  // fields are pushed from the snapshot on the following cycles.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (accept && bus.i_mode) begin
          state_d = SCAN;
          snap_d  = bus.i_data;
          idx_d   = '0;
        end
      end
      SCAN: begin
        if (push) begin
          idx_d = idx_q + SEL_W'(1);
          if (idx_q == {SEL_W{1'b1}}) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: choose the push source. In SCAN the upstream side is
  // closed (o_ready low), so the skid register being empty is the only
  // condition for a push to have somewhere to land.
  always_comb begin
    push      = 1'b0;
    push_beat = '0;
    if (state_q == SCAN) begin
      push           = ~s_valid_q;
      push_beat.data = snap_field[idx_q];
      push_beat.sel  = idx_q;
      push_beat.last = (idx_q == {SEL_W{1'b1}});
    end else begin
      push           = accept & ~bus.i_mode;
      push_beat.data = in_field[bus.i_sel];
      push_beat.sel  = bus.i_sel;
      push_beat.last = 1'b1;
    end
  end

  assign idle_d = (state_d == IDLE);
`else
  logic unused_mode;
  assign unused_mode = bus.i_mode;

  always_comb begin
    push           = accept;
    push_beat      = '0;
    push_beat.data = in_field[bus.i_sel];
    push_beat.sel  = bus.i_sel;
    push_beat.last = 1'b1;
  end

  assign idle_d = 1'b1;
`endif

  // Skid buffer. The main register always holds the oldest beat; the skid
  // register only fills when a push arrives while main is full and not
  // draining. A push is never offered while skid is full, so the skid
  // register is never overwritten.
  always_comb begin
    m_valid_d = m_valid_q;
    m_beat_d  = m_beat_q;
    s_valid_d = s_valid_q;
    s_beat_d  = s_beat_q;
    if (pop) begin
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_beat_d  = s_beat_q;
        s_valid_d = push;
        if (push) begin
          s_beat_d = push_beat;
        end
      end else begin
        m_valid_d = push;
        if (push) begin
          m_beat_d = push_beat;
        end
      end
    end else if (push) begin
      if (m_valid_q) begin
        s_valid_d = 1'b1;
        s_beat_d  = push_beat;
      end else begin
        m_valid_d = 1'b1;
        m_beat_d  = push_beat;
      end
    end
  end

  // o_ready is registered from next-state values so it already reflects
  // whether the skid register will be free in the coming cycle.
  assign ready_d = ~s_valid_d & idle_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_beat_q  <= '0;
      s_beat_q  <= '0;
      ready_q   <= 1'b1;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_beat_q  <= m_beat_d;
      s_beat_q  <= s_beat_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.o_valid = m_valid_q;
  assign bus.o_data  = m_beat_q.data;
  assign bus.o_sel   = m_beat_q.sel;
  assign bus.o_last  = m_beat_q.last;
  assign bus.o_ready = ready_q;
endmodule

// File: doc/field_mux_pipe.md
FIELD_MUX_PIPE -- requirements
Module: field_mux_pipe

Interface
REQ-001 Parameter W, default 3, bit width of one field.
REQ-002 Parameter SEL_W, default 2, select width; field count NCH = 2**SEL_W.
REQ-003 i_clk  input  1  single clock, all state updates on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_data  input  NCH*W  packed fields; field k = i_data[k*W +: W].
REQ-006 i_sel  input  SEL_W  field index, select mode.
REQ-007 i_mode  input  1  0 = select mode, 1 = scan mode.
REQ-008 i_valid  input  1  upstream beat valid.
REQ-009 o_ready  output  1  upstream may transfer; registered.
REQ-010 o_data  output  W  selected field.
REQ-011 o_sel  output  SEL_W  index of the field on o_data.
REQ-012 o_last  output  1  final beat of a transfer.
REQ-013 o_valid  output  1  downstream beat valid.
REQ-014 i_ready  input  1  downstream accepts.

Function
REQ-015 Input accept = i_valid & o_ready; output transfer = o_valid & i_ready.
REQ-016 Output stage SHALL be a 2-entry skid buffer (main register plus skid register); o_ready = skid register empty and FSM in IDLE, registered.
REQ-017 Select mode: accepted beat pushes field i_sel of i_data, o_sel = i_sel, o_last = 1; visible on o_data with o_valid the cycle after acceptance (latency 1).
REQ-018 Select mode SHALL sustain one beat per cycle while i_ready is held high.
REQ-019 FSM states IDLE and SCAN; IDLE -> SCAN on accept with i_mode = 1; SCAN -> IDLE after the push of field NCH-1.
REQ-020 On scan entry, i_data SHALL be captured into a snapshot register and index counter set to 0.
REQ-021 In SCAN, each cycle with output-stage space pushes snapshot field idx, o_sel = idx, o_last = (idx == NCH-1), then idx increments.
REQ-022 i_mode and i_sel SHALL be sampled only at acceptance; changes during SCAN have no effect.
REQ-023 o_valid held with i_ready low: o_data, o_sel, o_last SHALL stay stable until transfer.
REQ-024 Skid full: o_ready drops next cycle; a beat accepted in the cycle ready was still high is captured in the skid register, never lost or duplicated.
REQ-025 Simultaneous push and pop with one entry held: occupancy unchanged, order preserved.
REQ-026 Output order SHALL equal push order; no beat dropped under any i_ready pattern.

Reset
REQ-027 i_rst_n low SHALL immediately clear: o_valid = 0, o_data = 0, o_sel = 0, o_last = 0, skid empty, FSM = IDLE, idx = 0, snapshot = 0.
REQ-028 o_ready SHALL be 1 during and after reset.
REQ-029 Reset mid-scan SHALL abandon remaining fields; no residual beats after release.

Configuration
REQ-030 Macro FIELD_MUX_SCAN_EN defined: scan mode, FSM, snapshot and index counter present as specified.
REQ-031 Macro FIELD_MUX_SCAN_EN undefined: i_mode ignored, every accept handled as select mode, FSM/snapshot/counter absent, o_last constant 1.

Verification (W=3, SEL_W=2, i_data = 12'hAF1: field0=001, field1=110, field2=011, field3=101)
REQ-032 Reset: i_rst_n low mid-traffic -> o_valid 0, o_data 0, o_ready 1 same cycle without clock edge.
REQ-033 Select: i_sel 0,1,2,3 on consecutive cycles, i_ready = 1 -> o_data 001,110,011,101 one cycle later, o_last 1 each, no bubbles.
REQ-034 Backpressure: i_ready 0 for 3 cycles during 4-beat select stream -> o_ready low after second accept, all 4 beats delivered in order, outputs stable while stalled.
REQ-035 Scan (macro defined): i_mode 1, one accept -> o_data 001,110,011,101, o_sel 0..3, o_last only on 101; o_ready low until last push.
REQ-036 Scan with i_ready toggling 1/0 and i_data changed after accept -> still 001,110,011,101 from snapshot.
REQ-037 Macro undefined: i_mode 1, i_sel 2 -> single beat 011, o_last 1; reset asserted mid-scan (macro defined) -> no further beats after release.
